// File: rtl/seq_1010_tx.sv
// Serial frame transmitter: 4-bit preamble, DATA_W payload bits MSB first, optional even parity.
// Define SEQ_1010_TX_PARITY_EN to append the parity bit (PAR state); default build omits it.
module seq_1010_tx #(
  parameter int         DATA_W   = 8,
  parameter logic [3:0] PREAMBLE = 4'b1010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out,
  output logic              out_valid,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

`ifdef SEQ_1010_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, PRE, DATA, PAR} state_t;
  logic par;
`else
  typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;
`endif

  state_t            state;
  logic [DATA_W-1:0] sr;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        pidx;

  // done marks the final bit on out, which is exactly when the next word may enter.
  assign in_ready = !rst && (state == IDLE || done);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      pidx      <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_1010_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else if (state == IDLE || done) begin
      cnt  <= '0;
      pidx <= '0;
      done <= 1'b0;
      if (in_valid) begin
        state     <= PRE;
        sr        <= in_data;
        out       <= PREAMBLE[3];
        out_valid <= 1'b1;
`ifdef SEQ_1010_TX_PARITY_EN
        par       <= ^in_data;
`endif
      end else begin
        state     <= IDLE;
        out       <= 1'b0;
        out_valid <= 1'b0;
      end
    end else begin
      case (state)
        PRE: begin
          if (pidx == 2'd3) begin
            state <= DATA;
            out   <= sr[DATA_W-1];
            sr    <= sr << 1;
            cnt   <= CNT_W'(1);
`ifdef SEQ_1010_TX_PARITY_EN
            done  <= 1'b0;
`else
            done  <= (DATA_W == 1);
`endif
          end else begin
            pidx <= pidx + 2'd1;
            out  <= PREAMBLE[2'd2 - pidx];
          end
        end
        DATA: begin
`ifdef SEQ_1010_TX_PARITY_EN
          if (cnt == CNT_W'(DATA_W)) begin
            state <= PAR;
            out   <= par;
            done  <= 1'b1;
          end else begin
            out  <= sr[DATA_W-1];
            sr   <= sr << 1;
            cnt  <= cnt + CNT_W'(1);
            done <= 1'b0;
          end
`else
          out  <= sr[DATA_W-1];
          sr   <= sr << 1;
          cnt  <= cnt + CNT_W'(1);
          done <= (cnt == CNT_W'(DATA_W - 1));
`endif
        end
        default: begin
          state     <= IDLE;
          out       <= 1'b0;
          out_valid <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
